// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : IF-stage program counter and instruction-fetch control.
//            Selects the next PC from the sequential, branch or jump
//            sources. Drives the instruction-memory request and parks a
//            fetched word while ID is stalled. Loads the IF/ID register.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            pc_plus4                        - PC adder result for pc
//            branch_taken/branch_target      - EX branch redirect
//            jump/jump_target                - EX jump redirect (wins)
//            stall, flush                    - ID backpressure / squash
//            imem_ready, imem_instr          - instruction memory response
//            pc, imem_req, imem_addr         - current PC and fetch request
//            if_id_pc/pc4/instr/valid        - IF/ID pipeline register
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    input  logic        flush,
    input  logic        imem_ready,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    localparam logic [1:0] c_STATE_BOOT  = 2'd0;
    localparam logic [1:0] c_STATE_FETCH = 2'd1;
    localparam logic [1:0] c_STATE_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_holdWord;
    logic [31:0] r_ifIdPc;
    logic [31:0] r_ifIdPc4;
    logic [31:0] r_ifIdInstr;
    logic        r_ifIdValid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [1:0]  w_stateNext;
    logic [31:0] w_pcNext;
    logic        w_capture;
    logic        w_load;
    logic        w_bubble;
    logic [31:0] w_loadWord;

    // Jump has priority over branch; targets are forced word aligned.
    assign w_redirect = jump | branch_taken;
    assign w_target   = jump ? {jump_target[31:2], 2'b00}
                             : {branch_target[31:2], 2'b00};

    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_bubble    = flush;
        w_loadWord  = imem_instr;
        if (w_redirect) begin
            // Redirect overrides stall and abandons any fetched/parked word.
            w_pcNext    = w_target;
            w_bubble    = 1'b1;
            w_stateNext = c_STATE_FETCH;
        end else begin
            case (r_state)
                c_STATE_BOOT: begin
                    w_stateNext = c_STATE_FETCH;
                end
                c_STATE_FETCH: begin
                    if (imem_ready && !stall) begin
                        // A flushed word is dropped but the PC still moves on.
                        w_load   = !flush;
                        w_pcNext = pc_plus4;
                    end else if (imem_ready) begin
                        w_capture   = 1'b1;
                        w_stateNext = c_STATE_HOLD;
                    end else if (!stall) begin
                        w_bubble = 1'b1;
                    end
                end
                c_STATE_HOLD: begin
                    w_loadWord = r_holdWord;
                    if (!stall) begin
                        w_load      = !flush;
                        w_pcNext    = pc_plus4;
                        w_stateNext = c_STATE_FETCH;
                    end
                end
                default: begin
                    w_stateNext = c_STATE_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_STATE_BOOT;
            r_pc        <= RESET_PC;
            r_holdWord  <= 32'h0000_0000;
            r_ifIdPc    <= 32'h0000_0000;
            r_ifIdPc4   <= 32'h0000_0000;
            r_ifIdInstr <= NOP_INSTR;
            r_ifIdValid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            if (w_capture) begin
                r_holdWord <= imem_instr;
            end
            if (w_bubble) begin
                r_ifIdPc    <= 32'h0000_0000;
                r_ifIdPc4   <= 32'h0000_0000;
                r_ifIdInstr <= NOP_INSTR;
                r_ifIdValid <= 1'b0;
            end else if (w_load) begin
                r_ifIdPc    <= r_pc;
                r_ifIdPc4   <= pc_plus4;
                r_ifIdInstr <= w_loadWord;
                r_ifIdValid <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign imem_req    = (r_state == c_STATE_FETCH);
    assign imem_addr   = r_pc;
    assign if_id_pc    = r_ifIdPc;
    assign if_id_pc4   = r_ifIdPc4;
    assign if_id_instr = r_ifIdInstr;
    assign if_id_valid = r_ifIdValid;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. A transaction-level
//            model (PC, parked word, IF/ID contents) is compared against
//            the DUT every falling edge. Directed scenarios add literal
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_plus4;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int checks   = 0;
    int failures = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    assign pc_plus4   = pc + 32'd4;
    assign imem_instr = memWord(imem_addr);

    pc_fetch_unit #(
        .RESET_PC (c_RESET_PC),
        .NOP_INSTR(c_NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .stall        (stall),
        .flush        (flush),
        .imem_ready   (imem_ready),
        .imem_instr   (imem_instr),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // mBooted: first clock after reset seen. mHeld: a word is parked for ID.
    logic [31:0] mPc = c_RESET_PC;
    logic        mBooted = 1'b0;
    logic        mHeld = 1'b0;
    logic [31:0] mHeldWord = 32'h0;
    logic [31:0] mIfPc = 32'h0;
    logic [31:0] mIfPc4 = 32'h0;
    logic [31:0] mIfInstr = c_NOP;
    logic        mIfValid = 1'b0;

    function automatic logic [31:0] redirTarget();
        return jump ? (jump_target & ~32'd3) : (branch_target & ~32'd3);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPc <= c_RESET_PC; mBooted <= 1'b0; mHeld <= 1'b0; mHeldWord <= 32'h0;
            mIfPc <= 32'h0; mIfPc4 <= 32'h0; mIfInstr <= c_NOP; mIfValid <= 1'b0;
        end else if (jump || branch_taken) begin
            mPc <= redirTarget(); mBooted <= 1'b1; mHeld <= 1'b0;
            mIfPc <= 32'h0; mIfPc4 <= 32'h0; mIfInstr <= c_NOP; mIfValid <= 1'b0;
        end else begin
            // Decide whether ID receives a word, a bubble, or keeps its content.
            if (!mBooted) begin
                mBooted <= 1'b1;
            end else if (!stall && (mHeld || imem_ready)) begin
                mPc   <= mPc + 32'd4;
                mHeld <= 1'b0;
                if (!flush) begin
                    mIfPc <= mPc; mIfPc4 <= mPc + 32'd4;
                    mIfInstr <= mHeld ? mHeldWord : memWord(mPc); mIfValid <= 1'b1;
                end
            end else if (!mHeld && imem_ready) begin
                mHeld <= 1'b1;
                mHeldWord <= memWord(mPc);
            end
            if (flush || (mBooted && !mHeld && !imem_ready && !stall)) begin
                mIfPc <= 32'h0; mIfPc4 <= 32'h0; mIfInstr <= c_NOP; mIfValid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pc", pc, mPc);
            chk("imem_req", {31'h0, imem_req}, {31'h0, mBooted && !mHeld});
            chk("imem_addr", imem_addr, mPc);
            chk("if_id_pc", if_id_pc, mIfPc);
            chk("if_id_pc4", if_id_pc4, mIfPc4);
            chk("if_id_instr", if_id_instr, mIfInstr);
            chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, mIfValid});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        started = 1'b1;
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, c_NOP);
        rst_n = 1'b1;

        // Reset release with memory always ready
        step();
        chk("boot_req", {31'h0, imem_req}, 32'h1);
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
        step();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_ifpc0", if_id_pc, 32'h0);
        chk("seq_valid", {31'h0, if_id_valid}, 32'h1);
        chk("seq_instr0", if_id_instr, 32'hA5C3_0F00);
        step();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_ifpc4", if_id_pc, 32'h4);
        step(); step();
        chk("seq_pc10", pc, 32'h10);

        // Stall three cycles with ready high at 0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", pc, 32'h10);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_ifpc", if_id_pc, 32'hC);
        end
        stall = 1'b0;
        step();
        chk("unstall_ifpc", if_id_pc, 32'h10);
        chk("unstall_instr", if_id_instr, 32'hA5C3_0F10);
        chk("unstall_pc", pc, 32'h14);

        // Jump and branch together: jump wins, target aligned
        branch_taken = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h83;
        step();
        branch_taken = 1'b0; jump = 1'b0;
        chk("redir_pc", pc, 32'h80);
        chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h80);
        step();
        chk("redir_ifpc", if_id_pc, 32'h80);

        // Memory not ready for two cycles at 0x20
        jump = 1'b1; jump_target = 32'h20;
        step();
        jump = 1'b0; imem_ready = 1'b0;
        step(); step();
        chk("nrdy_pc", pc, 32'h20);
        chk("nrdy_valid", {31'h0, if_id_valid}, 32'h0);
        imem_ready = 1'b1;
        step();
        chk("rdy_ifpc", if_id_pc, 32'h20);
        chk("rdy_pc", pc, 32'h24);

        // Flush drops the accepted word but PC advances
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("flush_pc", pc, 32'h28);
        step();
        stall = 1'b1;
        step();
        flush = 1'b1;
        step();
        chk("flushstall_valid", {31'h0, if_id_valid}, 32'h0);
        chk("flushstall_pc", pc, 32'h2C);
        flush = 1'b0; stall = 1'b0;
        step();
        chk("afterhold_ifpc", if_id_pc, 32'h2C);
        chk("afterhold_instr", if_id_instr, 32'hA5C3_0F2C);

        // Wrap at top of address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_ifpc4", if_id_pc4, 32'h0);
        step();
        stall = 1'b1;
        step();
        chk("pre_rst_hold_pc", pc, 32'h4);

        // Asynchronous reset in the middle of HOLD
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("arst_instr", if_id_instr, c_NOP);
        chk("arst_ifpc", if_id_pc, 32'h0);
        step();
        stall = 1'b0; rst_n = 1'b1;
        step();
        chk("rel_valid", {31'h0, if_id_valid}, 32'h0);
        step();
        chk("rel_ifpc", if_id_pc, 32'h0);
        chk("rel_instr", if_id_instr, 32'hA5C3_0F00);
        step();
        chk("rel_ifpc4", if_id_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
